// File: rtl/serial_out_tx.sv
// ---------------------------------------------------------------------------
// serial_out_tx
//
// Output-side consumer of the FIFO drain stage. It takes one byte per
// out_start/out_finish handshake and sends it on an asynchronous TX line.
// Each frame is 1 start bit, 8 data bits LSB first, an optional parity bit,
// and 1 or 2 stop bits.
//
// Handshake: out_start is a level request. It is sampled only while the
// state register reads IDLE. out_finish=1 means idle and ready. The
// accepting edge drops out_finish, and out_finish rises again on the edge
// where the last stop bit completes. A request seen on that same edge is
// not taken until the next edge. A held-high out_start therefore produces
// frames separated by exactly one idle cycle. A 1-cycle out_start pulse is
// always enough.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high; abandons any frame in progress
//   out_start   byte-valid request (level)
//   out_data    byte to send, stable until sampled
//   out_finish  1 = idle/ready, 0 = frame in progress (registered)
//   tx          serial line, idle high (registered)
//   state       debug state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
// ---------------------------------------------------------------------------
module serial_out_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       out_start,
    input  logic [7:0] out_data,
    output logic       out_finish,
    output logic       tx,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY == 2);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        finish_q, finish_d;
    logic        cnt_done;

    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = tx_q;
        finish_d  = finish_q;

        // The baud counter runs in every non-idle state and wraps at
        // terminal count. This keeps each bit period exactly CLKS_PER_BIT.
        if (state_q != S_IDLE) begin
            cnt_d = cnt_done ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d     = 1'b1;
                finish_d = 1'b1;
                if (out_start) begin
                    shift_d   = out_data;
                    // Parity is computed from the whole byte at accept
                    // time, because the shift register is consumed as the
                    // bits go out.
                    par_d     = (^out_data) ^ PAR_ODD;
                    tx_d      = 1'b0;
                    finish_d  = 1'b0;
                    cnt_d     = 16'd0;
                    bit_idx_d = 3'd0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                if (cnt_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end

            S_DATA: begin
                if (cnt_done) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            S_PARITY: begin
                if (cnt_done) begin
                    tx_d      = 1'b1;
                    bit_idx_d = 3'd0;
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                // bit_idx counts stop-bit periods here.
                if (cnt_done) begin
                    if (bit_idx_q == STOP_LAST) begin
                        finish_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end

            default: begin
                tx_d     = 1'b1;
                finish_d = 1'b1;
                cnt_d    = 16'd0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            finish_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            finish_q  <= finish_d;
        end
    end

    assign tx         = tx_q;
    assign out_finish = finish_q;
    assign state      = state_q;

endmodule

// File: tb/tb_serial_out_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_out_tx
//
// Directed bench for serial_out_tx with CLKS_PER_BIT=4. It uses three
// instances:
//   0: no parity, 1 stop bit
//   1: even parity, 2 stop bits
//   2: odd parity, 2 stop bits
// Every expected tx, out_finish and state value is written out by hand in
// the steps below.
// ---------------------------------------------------------------------------
module tb_serial_out_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start_r;
    logic [7:0] data_r [3];
    logic [2:0] tx_w;
    logic [2:0] fin_w;
    logic [2:0] st_w [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_out_tx #(.CLKS_PER_BIT(N), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset), .out_start(start_r[0]), .out_data(data_r[0]),
        .out_finish(fin_w[0]), .tx(tx_w[0]), .state(st_w[0]));

    serial_out_tx #(.CLKS_PER_BIT(N), .PARITY(1), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset), .out_start(start_r[1]), .out_data(data_r[1]),
        .out_finish(fin_w[1]), .tx(tx_w[1]), .state(st_w[1]));

    serial_out_tx #(.CLKS_PER_BIT(N), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset(reset), .out_start(start_r[2]), .out_data(data_r[2]),
        .out_finish(fin_w[2]), .tx(tx_w[2]), .state(st_w[2]));

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check that all three instances sit idle for n sampled cycles.
    task automatic idle_all(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_tx%0d_c%0d", tag, i, c), {7'd0, tx_w[i]}, 8'd1);
                check($sformatf("%s_fin%0d_c%0d", tag, i, c), {7'd0, fin_w[i]}, 8'd1);
                check($sformatf("%s_st%0d_c%0d", tag, i, c), {5'd0, st_w[i]}, 8'd0);
            end
            tick();
        end
    endtask

    // Send one byte on instance i and check every cycle of the frame.
    //   par_en/par_bit: whether a parity bit is expected, and its
    //                   hand-computed value.
    //   hold:           leave out_start high after the accept cycle.
    //   inject:         frame cycle at which a 1-cycle out_start pulse with
    //                   8'h3C is applied (-1 disables it).
    task automatic send(input string tag, input int i, input logic [7:0] d,
                        input bit par_en, input bit par_bit, input int stops,
                        input bit hold, input int inject);
        logic       exp_bit[$];
        logic [2:0] exp_st[$];
        int         cyc;
        exp_bit.push_back(1'b0); exp_st.push_back(3'd1);
        for (int k = 0; k < 8; k++) begin
            exp_bit.push_back(d[k]); exp_st.push_back(3'd2);
        end
        if (par_en) begin
            exp_bit.push_back(par_bit); exp_st.push_back(3'd3);
        end
        for (int k = 0; k < stops; k++) begin
            exp_bit.push_back(1'b1); exp_st.push_back(3'd4);
        end

        start_r[i] = 1'b1;
        data_r[i]  = d;
        tick();
        cyc = 0;
        for (int b = 0; b < exp_bit.size(); b++) begin
            for (int c = 0; c < N; c++) begin
                check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), {7'd0, tx_w[i]}, {7'd0, exp_bit[b]});
                check($sformatf("%s_fin_b%0d_c%0d", tag, b, c), {7'd0, fin_w[i]}, 8'd0);
                check($sformatf("%s_st_b%0d_c%0d", tag, b, c), {5'd0, st_w[i]}, {5'd0, exp_st[b]});
                cyc++;
                if (cyc == inject) begin
                    start_r[i] = 1'b1;
                    data_r[i]  = 8'h3C;
                end else if (!hold) begin
                    start_r[i] = 1'b0;
                end
                tick();
            end
        end
        check($sformatf("%s_end_fin", tag), {7'd0, fin_w[i]}, 8'd1);
        check($sformatf("%s_end_tx", tag), {7'd0, tx_w[i]}, 8'd1);
        check($sformatf("%s_end_st", tag), {5'd0, st_w[i]}, 8'd0);
    endtask

    initial begin
        reset   = 1'b1;
        start_r = 3'b000;
        for (int i = 0; i < 3; i++) data_r[i] = 8'h00;

        // Reset held for 3 cycles, then released with out_start low.
        repeat (3) tick();
        idle_all("reset", 1);
        reset = 1'b0;
        idle_all("idle", 20);

        // 8'hA5 frame: 0,1,0,1,0,0,1,0,1,1; out_finish low for 40 cycles.
        send("a5", 0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, -1);
        idle_all("post_a5", 3);

        // 8'h07 with even parity gives parity bit 1; 2 stop bits; 48 cycles.
        send("even07", 1, 8'h07, 1'b1, 1'b1, 2, 1'b0, -1);
        // The same byte with odd parity gives parity bit 0.
        send("odd07", 2, 8'h07, 1'b1, 1'b0, 2, 1'b0, -1);
        idle_all("post_par", 2);

        // A mid-frame 8'h3C pulse during 8'h81 must leave the line
        // carrying 8'h81 only.
        send("busy81", 0, 8'h81, 1'b0, 1'b0, 1, 1'b0, 20);
        start_r[0] = 1'b0;
        idle_all("post_busy", 8);

        // out_start held high with 8'h55: one idle cycle between frames.
        send("b2b_1", 0, 8'h55, 1'b0, 1'b0, 1, 1'b1, -1);
        send("b2b_2", 0, 8'h55, 1'b0, 1'b0, 1, 1'b0, -1);
        idle_all("post_b2b", 4);

        // Reset during DATA bit 3 of 8'h00; tx is low there, so a return
        // to high is visible.
        start_r[0] = 1'b1;
        data_r[0]  = 8'h00;
        tick();
        start_r[0] = 1'b0;
        repeat (17) tick();
        check("mid_st_data", {5'd0, st_w[0]}, 8'd2);
        check("mid_tx_low", {7'd0, tx_w[0]}, 8'd0);
        check("mid_fin_low", {7'd0, fin_w[0]}, 8'd0);
        reset = 1'b1;
        tick();
        check("rst_mid_tx", {7'd0, tx_w[0]}, 8'd1);
        check("rst_mid_fin", {7'd0, fin_w[0]}, 8'd1);
        check("rst_mid_st", {5'd0, st_w[0]}, 8'd0);
        reset = 1'b0;
        send("after_rst", 0, 8'hA5, 1'b0, 1'b0, 1, 1'b0, -1);
        idle_all("final", 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_out_tx.md
Name: serial_out_tx

Overview:
- Output-side consumer of the FIFO drain stage. Accepts one byte per out_start/out_finish handshake and serialises it onto an asynchronous TX line: 1 start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- out_finish doubles as the "ready/idle" indication the drain stage polls before fetching the next FIFO byte.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- out_start  input  1  byte-valid request from the drain stage; level, sampled only in IDLE.
- out_data  input  8  byte to send; stable from before out_start rises until it is sampled.
- out_finish  output  1  1 = idle/ready for a byte, 0 = frame in progress.
- tx  output  1  serial line, idle high.
- state  output  3  debug state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.

Behaviour:
- Reset (synchronous, active-high), on the clk edge where reset=1:
  - tx=1, out_finish=1, state=IDLE.
  - Baud counter, bit index and shift register cleared.
  - Reset overrides everything, including mid-frame; the partial frame is abandoned and tx returns high on that edge.
- IDLE:
  - tx=1, out_finish=1.
  - On an edge with out_start=1: shift_reg<=out_data, tx<=0, out_finish<=0, baud counter<=0, state<=START.
  - The drain stage sees out_finish still 1 on this same edge and deasserts out_start after one cycle. A 1-cycle out_start pulse is therefore sufficient and must be accepted.
- Baud timing:
  - Each bit is held on tx for exactly CLKS_PER_BIT cycles.
  - Counter counts 0..CLKS_PER_BIT-1; at terminal count the next bit's tx value is registered.
- START: after CLKS_PER_BIT cycles -> DATA; tx<=shift_reg[0], bit index<=0.
- DATA:
  - At each terminal count, shift right and send the next bit; after bit 7 completes -> PARITY if PARITY!=0, else STOP.
  - On entering PARITY: tx<=XOR of the 8 bits (even), or its inverse (odd).
  - On entering STOP: tx<=1.
- PARITY: one bit period, then -> STOP with tx<=1.
- STOP:
  - Hold tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the final terminal count: out_finish<=1, state<=IDLE.
- Frame length: (10 + (PARITY!=0) + STOP_BITS - 1) * CLKS_PER_BIT cycles from the accept edge to the edge where out_finish rises. With defaults this is 10*CLKS_PER_BIT.
- Simultaneous events:
  - out_start=1 on the edge where STOP completes is ignored. The state register is not yet IDLE, so the request is accepted on the next edge if still high.
  - out_start held high continuously gives back-to-back frames with exactly one idle cycle (tx=1, out_finish=1) between them.
- Busy: out_start and out_data are ignored outside IDLE; the latched byte cannot be corrupted mid-frame.
- Width: baud counter is 16 bits, bit index 3 bits; no other arithmetic.
- out_finish and tx are registered outputs (no combinational paths from inputs).

Test Plan:
- Reset/idle: CLKS_PER_BIT=4; hold reset 3 cycles, release with out_start=0 -> tx=1, out_finish=1, state=0 for 20 cycles.
- Single byte: 1-cycle out_start with out_data=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 (4 cycles each); out_finish low for exactly 40 cycles, then high.
- Parity/stop: PARITY=1, STOP_BITS=2, data=8'h07 -> parity bit 1, then two stop bit-times; out_finish low for 48 cycles. Repeat with PARITY=2 -> parity bit 0.
- Busy ignore: pulse out_start with 8'h3C mid-frame of 8'h81 -> line carries only 8'h81; 8'h3C is never sent.
- Back-to-back: hold out_start=1 with data 8'h55 -> consecutive frames separated by exactly one idle cycle; out_finish pulses high for 1 cycle between frames.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1, out_finish=1, state=0 on that edge; a following out_start sends a clean full frame.
